if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, number of buffered fetch entries; power of two, minimum 2.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, fetch stage presents an entry.
REQ-005 The block SHALL have port in_ready, output, 1, buffer accepts an entry this cycle.
REQ-006 The block SHALL have port in_pc, input, `LEGV8_INTEGER_SZ, address of the fetched instruction.
REQ-007 The block SHALL have port in_instr, input, `LEGV8_INSTRUCTION_SZ, fetched instruction word.
REQ-008 The block SHALL have port flush, input, 1, discard all entries (taken branch / redirect).
REQ-009 The block SHALL have port out_valid, output, 1, head entry is available to decode.
REQ-010 The block SHALL have port out_ready, input, 1, decode consumes the head entry.
REQ-011 The block SHALL have port out_pc, output, `LEGV8_INTEGER_SZ, head entry address.
REQ-012 The block SHALL have port out_instr, output, `LEGV8_INSTRUCTION_SZ, head entry instruction.
REQ-013 The block SHALL have port occupancy, output, $clog2(DEPTH+1), current entry count.

Function
REQ-014 The block SHALL be a DEPTH-entry FIFO of {pc, instr} with read/write pointers wrapping modulo DEPTH.
REQ-015 Push SHALL occur iff in_valid && in_ready && !flush; pop SHALL occur iff out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (occupancy < DEPTH), derived from registered state only, with no dependency on out_ready.
REQ-017 out_valid SHALL equal (occupancy != 0); out_pc/out_instr SHALL show the head entry.
REQ-018 Base latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-020 When full, in_ready SHALL be 0 even if out_ready is 1; the pop proceeds and in_ready rises next cycle.
REQ-021 When empty, out_ready SHALL have no effect and out_pc/out_instr SHALL hold the last-written storage value.
REQ-022 flush SHALL synchronously reset pointers and occupancy to 0, discard any same-cycle push, and perform no pop; out_valid SHALL be 0 the following cycle.
REQ-023 Entries SHALL leave in push order with no duplication or loss; in_pc/in_instr SHALL be captured unmodified.

Reset
REQ-024 reset_n low SHALL asynchronously clear pointers, occupancy, and all storage to 0.
REQ-025 During and after reset: out_valid=0, in_ready=1, occupancy=0, out_pc=0, out_instr=0.
REQ-026 Reset asserted mid-operation SHALL drop all entries; first push after deassertion SHALL land in entry 0.

Configuration
REQ-027 Macro LEGV8_IFID_BYPASS_EN defined: when occupancy==0, in_valid=1, out_ready=1 and flush=0, in_* SHALL pass combinationally to out_* with out_valid=1, and the entry SHALL NOT be written (zero latency).
REQ-028 Macro LEGV8_IFID_BYPASS_EN undefined: no combinational in-to-out path; latency is exactly 1 cycle per REQ-018.

Verification
REQ-029 Reset, then in_valid=1, in_pc=0x0, in_instr=0x8B020020, out_ready=0 for 1 cycle -> next cycle out_valid=1, out_pc=0x0, out_instr=0x8B020020, occupancy=1.
REQ-030 DEPTH=2, push pc 0x0, 0x4, 0x8 back-to-back with out_ready=0 -> occupancy=2, in_ready=0, pc 0x8 not accepted; then out_ready=1 -> outputs 0x0, 0x4 in order.
REQ-031 Full buffer, in_valid=1, out_ready=1 -> pop that cycle, in_ready=1 next cycle, occupancy 1 then stays at 1 under continuous streaming.
REQ-032 Occupancy=2 with flush=1 and in_valid=1 (pc 0x40) -> next cycle occupancy=0, out_valid=0; pc 0x40 never appears on out_pc.
REQ-033 Stream 10 entries pc 0x0..0x24 step 4 with random out_ready -> output sequence identical and pointers wrap at least twice.
REQ-034 With LEGV8_IFID_BYPASS_EN: empty, in_valid=1, in_pc=0x10, out_ready=1 -> same-cycle out_valid=1, out_pc=0x10, occupancy stays 0; without macro -> out_valid=0 that cycle.

Source files
------------

// File: rtl/if_id_buffer.sv
`default_nettype none

`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif
`ifndef LEGV8_INSTRUCTION_SZ
`define LEGV8_INSTRUCTION_SZ 32
`endif

// ============================================================================
// Module   : if_id_buffer
// Purpose  : Elastic buffer between the fetch and decode stages. It is a
//            DEPTH-entry FIFO of {pc, instr}. The read and write pointers wrap
//            modulo DEPTH. A flush empties the buffer in one cycle.
// Revision : 1.0 - initial release
//
// Parameters
//   DEPTH      number of buffered entries (power of two, >= 2)
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   reset_n    asynchronous active-low reset (clears pointers, count, storage)
//   in_valid   fetch presents an entry
//   in_ready   buffer can accept an entry (registered state only)
//   in_pc      address of the fetched instruction
//   in_instr   fetched instruction word
//   flush      discard all entries; same-cycle push dropped, no pop
//   out_valid  head entry is available to decode
//   out_ready  decode consumes the head entry
//   out_pc     head entry address
//   out_instr  head entry instruction
//   occupancy  current entry count
//
// Configuration
//   LEGV8_IFID_BYPASS_EN  when defined, an empty buffer forwards in_* to
//                         out_* combinationally if decode is ready, and does
//                         not store the entry (zero latency).
// ============================================================================
module if_id_buffer #(
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [`LEGV8_INTEGER_SZ-1:0]      in_pc,
   input  logic [`LEGV8_INSTRUCTION_SZ-1:0]  in_instr,
   input  logic                              flush,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [`LEGV8_INTEGER_SZ-1:0]      out_pc,
   output logic [`LEGV8_INSTRUCTION_SZ-1:0]  out_instr,
   output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] FULL_COUNT = OW'(DEPTH);

   logic [AW-1:0]                     wr_ptr;
   logic [AW-1:0]                     rd_ptr;
   logic [OW-1:0]                     count;
   logic [`LEGV8_INTEGER_SZ-1:0]      pc_mem    [DEPTH];
   logic [`LEGV8_INSTRUCTION_SZ-1:0]  instr_mem [DEPTH];

   logic bypass;
   logic push;
   logic pop;

   // in_ready depends only on the registered count. This keeps a full buffer
   // from accepting an entry in the same cycle that decode drains one.
   assign in_ready  = (count < FULL_COUNT);
   assign occupancy = count;

`ifdef LEGV8_IFID_BYPASS_EN
   assign bypass = (count == '0) && in_valid && out_ready && !flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry goes straight to decode, so it is not stored.
   assign push = in_valid && in_ready && !flush && !bypass;
   assign pop  = (count != '0) && out_ready && !flush;

   // Pointers and count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + OW'(1);
            2'b01:   count <= count - OW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage. A flush does not clear storage; only pointers and count are reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]    <= in_pc;
         instr_mem[wr_ptr] <= in_instr;
      end
   end

   // Head presentation. When the buffer is empty, the head slot holds the
   // last value written there.
   always_comb begin
      out_valid = (count != '0);
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
`ifdef LEGV8_IFID_BYPASS_EN
      if (bypass) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_instr = in_instr;
      end
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none

`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif
`ifndef LEGV8_INSTRUCTION_SZ
`define LEGV8_INSTRUCTION_SZ 32
`endif

// ============================================================================
// Module   : tb_if_id_buffer
// Purpose  : Self-checking bench for if_id_buffer. A queue-based reference
//            model predicts the head, valid, ready and occupancy values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

   localparam int DEPTH = 2;
   localparam int OW    = $clog2(DEPTH + 1);
`ifdef LEGV8_IFID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                             clk;
   logic                             reset_n;
   logic                             in_valid;
   logic                             in_ready;
   logic [`LEGV8_INTEGER_SZ-1:0]     in_pc;
   logic [`LEGV8_INSTRUCTION_SZ-1:0] in_instr;
   logic                             flush;
   logic                             out_valid;
   logic                             out_ready;
   logic [`LEGV8_INTEGER_SZ-1:0]     out_pc;
   logic [`LEGV8_INSTRUCTION_SZ-1:0] out_instr;
   logic [OW-1:0]                    occupancy;

   if_id_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the FIFO contents in push order
   logic [63:0] q_pc[$];
   logic [31:0] q_instr[$];
   bit          last_push;
   int          pushes;
   int          pops;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs and check the outputs before the next edge.
   // Then advance the model to the state after that edge.
   task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
      int  occ;
      bit  byp;
      bit  rdy;
      bit  do_pop;
      bit  do_push;
      @(negedge clk);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      #1;
      occ = q_pc.size();
      rdy = (occ < DEPTH);
      byp = BYP && (occ == 0) && v && ordy && !fl;
      check("occupancy", 64'(occupancy), 64'(occ));
      check("in_ready",  64'(in_ready),  64'(rdy));
      check("out_valid", 64'(out_valid), 64'((occ != 0) || byp));
      if (byp) begin
         check("bypass_pc",    out_pc,           pc);
         check("bypass_instr", 64'(out_instr),   64'(ins));
      end else if (occ != 0) begin
         check("head_pc",      out_pc,           q_pc[0]);
         check("head_instr",   64'(out_instr),   64'(q_instr[0]));
      end
      last_push = 1'b0;
      if (fl) begin
         q_pc.delete();
         q_instr.delete();
      end else begin
         do_pop  = (occ != 0) && ordy;
         do_push = v && rdy && !byp;
         if (do_pop) begin
            void'(q_pc.pop_front());
            void'(q_instr.pop_front());
            pops++;
         end
         if (do_push) begin
            q_pc.push_back(pc);
            q_instr.push_back(ins);
         end
         last_push = do_push || byp;
         if (byp) pops++;
      end
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      logic [63:0] next_pc;
      int          guard;

      idle_inputs();
      reset_n = 1'b0;
      pushes  = 0;
      pops    = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_pc",    out_pc,         64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single push, then observe it one cycle later
      step(1, 64'h0, 32'h8B020020, 0, 0);
      step(0, 64'h0, 32'h0, 0, 0);
      step(0, 64'h0, 32'h0, 1, 0);
      step(0, 64'h0, 32'h0, 0, 0);

      // Fill DEPTH=2, the third push is refused, then drain in order
      step(1, 64'h0, 32'hA0000000, 0, 0);
      step(1, 64'h4, 32'hA0000004, 0, 0);
      step(1, 64'h8, 32'hA0000008, 0, 0);
      check("full_refused_8", 64'(last_push), 64'd0);
      step(0, 64'h0, 32'h0, 1, 0);
      step(0, 64'h0, 32'h0, 1, 0);
      step(0, 64'h0, 32'h0, 1, 0);

      // Full with continuous streaming: occupancy then settles at 1
      step(1, 64'h100, 32'h1, 0, 0);
      step(1, 64'h104, 32'h2, 0, 0);
      for (int i = 0; i < 6; i++)
         step(1, 64'h108 + 64'(4 * i), 32'h10 + 32'(i), 1, 0);
      step(0, 64'h0, 32'h0, 1, 0);
      step(0, 64'h0, 32'h0, 1, 0);

      // Flush with a concurrent push of 0x40: that entry is discarded
      step(1, 64'h30, 32'h30, 0, 0);
      step(1, 64'h34, 32'h34, 0, 0);
      step(1, 64'h40, 32'h40, 0, 1);
      step(0, 64'h0, 32'h0, 1, 0);
      check("post_flush_no_40", 64'(out_pc == 64'h40 && out_valid), 64'd0);

      // Stream 10 entries 0x0..0x24 with random out_ready
      next_pc = 64'h0;
      guard   = 0;
      pushes  = 0;
      while (pushes < 10 && guard < 200) begin
         step(1, next_pc, 32'hC0000000 | 32'(next_pc), 1'($urandom_range(0, 1)), 0);
         if (last_push) begin
            next_pc += 64'h4;
            pushes++;
         end
         guard++;
      end
      check("stream_pushed_10", 64'(pushes), 64'd10);
      guard = 0;
      while (q_pc.size() != 0 && guard < 50) begin
         step(0, 64'h0, 32'h0, 1, 0);
         guard++;
      end
      check("stream_drained", 64'(q_pc.size()), 64'd0);

      // Random traffic with occasional flush
      next_pc = 64'h1000;
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), next_pc, $urandom(),
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
         if (last_push) next_pc += 64'h4;
      end

      // Reset asserted mid-operation drops entries and clears storage
      step(1, 64'h2000, 32'h2000, 0, 0);
      @(negedge clk);
      idle_inputs();
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_occupancy", 64'(occupancy), 64'd0);
      check("midrst_out_pc",    out_pc,         64'd0);
      check("midrst_in_ready",  64'(in_ready),  64'd1);
      q_pc.delete();
      q_instr.delete();
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 64'h3000, 32'h3000, 0, 0);
      step(0, 64'h0, 32'h0, 1, 0);
      step(0, 64'h0, 32'h0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
